// File: rtl/adder_eval_pkg.sv
// Shared types and constants for the approximate-adder error monitor.
// Holds the run FSM encoding, the operand LFSR polynomial and default seeds.
package adder_eval_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_POLY      = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED_A = 32'hACE1_1234;
  localparam logic [31:0] DEFAULT_SEED_B = 32'h5EED_0001;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/eval_lfsr32.sv
// 32-bit Galois LFSR operand source with synchronous reload and step enable.
// Reset returns the register to RST_SEED, which the parent ties to its seed port.
module eval_lfsr32
  import adder_eval_pkg::*;
#(
  parameter logic [31:0] RST_SEED = DEFAULT_SEED_A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] q
);

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_SEED;
    end else if (load) begin
      q <= seed;
    end else if (advance) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/adder_err_monitor.sv
// Drives pseudo-random operands into an external approximate adder and
// accumulates error-distance statistics (count, large count, sum, max).
module adder_err_monitor
  import adder_eval_pkg::*;
#(
  parameter int          N      = 16,
  parameter int          K      = 12,
  parameter int          CNT_W  = 32,
  parameter int          ACC_W  = 48,
  parameter int          USE_CO = 0,
  parameter logic [31:0] SEED_A = DEFAULT_SEED_A,
  parameter logic [31:0] SEED_B = DEFAULT_SEED_B
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  output logic [N-1:0]     op_a,
  output logic [N-1:0]     op_b,
  output logic             op_valid,
  input  logic [N-1:0]     approx_sum,
  input  logic             approx_co,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] large_err_count,
  output logic [ACC_W-1:0] sum_ed,
  output logic [N:0]       max_ed
);

  localparam int SUM_W = ((ACC_W > N + 1) ? ACC_W : N + 1) + 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] remaining;
  logic             drain_cnt;
  logic             accept, issue;
  logic [31:0]      lfsr_a_q, lfsr_b_q;
  logic [N:0]       exact, approx_v, ed;
  logic [N:0]       ed_q;
  logic             ed_v;
  logic [SUM_W-1:0] sum_ext;
  logic [ACC_W-1:0] sum_nxt;
  logic             unused_lfsr_bits;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign issue  = (state == RUN) && (remaining != '0);
  assign busy   = (state == RUN) || (state == DRAIN);

  eval_lfsr32 #(.RST_SEED(SEED_A)) u_lfsr_a (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .seed    (SEED_A),
    .advance (issue),
    .q       (lfsr_a_q)
  );

  eval_lfsr32 #(.RST_SEED(SEED_B)) u_lfsr_b (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .seed    (SEED_B),
    .advance (issue),
    .q       (lfsr_b_q)
  );

  // Only the low N bits feed the adder; the rest of each LFSR is pure state.
  assign unused_lfsr_bits = ^{lfsr_a_q[31:N], lfsr_b_q[31:N]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = (num_samples == '0) ? DONE : RUN;
      RUN:        if (remaining == '0) state_nxt = DRAIN;
      DRAIN:      if (drain_cnt) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    exact    = {1'b0, op_a} + {1'b0, op_b};
    approx_v = {approx_co, approx_sum};
    if (USE_CO == 0) begin
      exact[N]    = 1'b0;
      approx_v[N] = 1'b0;
    end
    ed = (approx_v >= exact) ? (approx_v - exact) : (exact - approx_v);
  end

  // Widened add so saturation is detected even when ACC_W is narrower than ED.
  always_comb begin
    sum_ext = SUM_W'(sum_ed) + SUM_W'(ed_q);
    sum_nxt = (sum_ext > SUM_W'({ACC_W{1'b1}})) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining       <= '0;
      drain_cnt       <= 1'b0;
      op_valid        <= 1'b0;
      op_a            <= '0;
      op_b            <= '0;
      ed_q            <= '0;
      ed_v            <= 1'b0;
      done            <= 1'b0;
      err_count       <= '0;
      large_err_count <= '0;
      sum_ed          <= '0;
      max_ed          <= '0;
    end else begin
      op_valid  <= issue;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      done      <= (state_nxt == DONE);
      ed_q      <= ed;
      ed_v      <= op_valid;

      if (issue) begin
        op_a      <= lfsr_a_q[N-1:0];
        op_b      <= lfsr_b_q[N-1:0];
        remaining <= remaining - CNT_W'(1);
      end

      if (accept) begin
        remaining       <= num_samples;
        err_count       <= '0;
        large_err_count <= '0;
        sum_ed          <= '0;
        max_ed          <= '0;
      end else if (ed_v) begin
        if ((ed_q != '0) && (err_count != '1))
          err_count <= err_count + CNT_W'(1);
        if (((ed_q >> K) != '0) && (large_err_count != '1))
          large_err_count <= large_err_count + CNT_W'(1);
        sum_ed <= sum_nxt;
        if (ed_q > max_ed) max_ed <= ed_q;
      end
    end
  end

endmodule

// File: tb/tb_adder_err_monitor.sv
// Randomized self-checking bench: a behavioural model of the operand stream
// and error statistics is compared against two monitor instances.
module tb_adder_err_monitor;

  logic        clk = 1'b0;
  logic        rst, start, sel;
  logic [31:0] num_samples;
  int          mode;
  logic [15:0] mask;

  logic [15:0] op_a0, op_b0, approx_sum0, op_a1, op_b1, approx_sum1;
  logic        op_valid0, busy0, done0, approx_co0;
  logic        op_valid1, busy1, done1, approx_co1;
  logic [31:0] err0, lerr0, err1, lerr1;
  logic [47:0] sum0;
  logic [7:0]  sum1;
  logic [16:0] max0, max1;
  logic        start0, start1;

  logic        m_op_valid, m_busy, m_done;
  logic [15:0] m_op_a, m_op_b;
  logic [31:0] m_err, m_lerr;
  logic [47:0] m_sum;
  logic [16:0] m_max;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External approximate adder stub: exact sum perturbed according to mode.
  function automatic logic [16:0] stub(input int m, input logic [15:0] msk,
                                       input logic [15:0] a, input logic [15:0] b);
    logic [16:0] ex;
    logic [15:0] lo;
    ex = {1'b0, a} + {1'b0, b};
    lo = ex[15:0];
    case (m)
      1:       return ex ^ 17'h00001;
      2:       return ex ^ 17'h01000;
      3:       return {~ex[16], lo ^ msk};
      4:       return {ex[16], (lo >= 16'd255) ? lo - 16'd255 : lo + 16'd255};
      5:       return {ex[16], lo & ~{8'h00, msk[7:0]}};
      default: return ex;
    endcase
  endfunction

  function automatic logic [31:0] model_lfsr(input logic [31:0] s);
    logic fb;
    fb = s[0];
    s  = s >> 1;
    if (fb) s = s ^ ((32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1);
    return s;
  endfunction

  assign start0 = start && !sel;
  assign start1 = start && sel;
  assign {approx_co0, approx_sum0} = stub(mode, mask, op_a0, op_b0);
  assign {approx_co1, approx_sum1} = stub(mode, mask, op_a1, op_b1);

  assign m_op_valid = sel ? op_valid1 : op_valid0;
  assign m_busy     = sel ? busy1     : busy0;
  assign m_done     = sel ? done1     : done0;
  assign m_op_a     = sel ? op_a1     : op_a0;
  assign m_op_b     = sel ? op_b1     : op_b0;
  assign m_err      = sel ? err1      : err0;
  assign m_lerr     = sel ? lerr1     : lerr0;
  assign m_sum      = sel ? {40'h0, sum1} : sum0;
  assign m_max      = sel ? max1      : max0;

  adder_err_monitor dut (
    .clk (clk), .rst (rst), .start (start0), .num_samples (num_samples),
    .op_a (op_a0), .op_b (op_b0), .op_valid (op_valid0),
    .approx_sum (approx_sum0), .approx_co (approx_co0),
    .busy (busy0), .done (done0), .err_count (err0), .large_err_count (lerr0),
    .sum_ed (sum0), .max_ed (max0)
  );

  adder_err_monitor #(.ACC_W(8)) dut_sat (
    .clk (clk), .rst (rst), .start (start1), .num_samples (num_samples),
    .op_a (op_a1), .op_b (op_b1), .op_valid (op_valid1),
    .approx_sum (approx_sum1), .approx_co (approx_co1),
    .busy (busy1), .done (done1), .err_count (err1), .large_err_count (lerr1),
    .sum_ed (sum1), .max_ed (max1)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy0, done0, op_valid0, op_a0, op_b0} !== '0) begin
      errors++;
      $display("FAIL reset_status: got busy=%0b done=%0b op_valid=%0b op_a=%h op_b=%h, want all 0",
               busy0, done0, op_valid0, op_a0, op_b0);
    end
    checks++;
    if ({err0, lerr0, sum0, max0, err1, lerr1, sum1, max1} !== '0) begin
      errors++;
      $display("FAIL reset_results: got err=%0d lerr=%0d sum=%0d max=%0d sat_sum=%0d, want 0",
               err0, lerr0, sum0, max0, sum1);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One complete run on the selected instance, checked against the model.
  task automatic do_run(input string tag, input bit s, input int m, input int n,
                        input int acc_w, input int poke);
    logic [31:0] sa, sb;
    logic [15:0] ea[$], eb[$];
    logic [16:0] r;
    longint e_err, e_lerr, e_sum, e_max, lim;
    int ap, ex, ed, idx, last_k, done_k, op_bad, gap_bad, busy_bad;
    bit seen_done;

    sa = 32'hACE1_1234; sb = 32'h5EED_0001;
    e_err = 0; e_lerr = 0; e_sum = 0; e_max = 0;
    for (int i = 0; i < n; i++) begin
      ea.push_back(sa[15:0]);
      eb.push_back(sb[15:0]);
      r  = stub(m, mask, sa[15:0], sb[15:0]);
      ap = int'(r[15:0]);
      ex = (int'(sa[15:0]) + int'(sb[15:0])) % 65536;
      ed = (ap > ex) ? ap - ex : ex - ap;
      if (ed != 0)    e_err++;
      if (ed >= 4096) e_lerr++;
      e_sum += ed;
      if (ed > e_max) e_max = ed;
      sa = model_lfsr(sa);
      sb = model_lfsr(sb);
    end
    lim = (longint'(1) << acc_w) - 1;
    if (e_sum > lim) e_sum = lim;

    sel = s; mode = m; num_samples = n;
    @(negedge clk);
    start = 1'b1;
    idx = 0; last_k = -1; done_k = -1; op_bad = 0; gap_bad = 0; busy_bad = 0;
    seen_done = 1'b0;
    for (int k = 1; k <= n + 12 && !seen_done; k++) begin
      @(negedge clk);
      start = (k == poke);
      if (m_op_valid) begin
        if (idx >= n) op_bad++;
        else if (m_op_a !== ea[idx] || m_op_b !== eb[idx]) begin
          if (op_bad == 0)
            $display("FAIL %s_operands: sample %0d got a=%h b=%h, want a=%h b=%h",
                     tag, idx, m_op_a, m_op_b, ea[idx], eb[idx]);
          op_bad++;
        end
        if (last_k != -1 && last_k != k - 1) gap_bad++;
        idx++;
        last_k = k;
      end
      if (m_done) begin
        seen_done = 1'b1;
        done_k = k;
      end else if (n > 0 && !m_busy) busy_bad++;
    end
    start = 1'b0;

    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL %s_done_timeout: done not seen within %0d cycles", tag, n + 12);
    end
    checks++;
    if (op_bad != 0 || gap_bad != 0) begin
      errors++;
      $display("FAIL %s_op_stream: got %0d operand mismatches and %0d gaps, want 0", tag, op_bad, gap_bad);
    end
    checks++;
    if (idx != n) begin
      errors++;
      $display("FAIL %s_valid_count: got %0d op_valid cycles, want %0d", tag, idx, n);
    end
    checks++;
    if (done_k != ((n == 0) ? 1 : last_k + 3)) begin
      errors++;
      $display("FAIL %s_done_latency: got done at cycle %0d, want %0d", tag, done_k,
               (n == 0) ? 1 : last_k + 3);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL %s_busy: got %0d non-busy cycles before done, want 0", tag, busy_bad);
    end

    // Results are compared after lingering in DONE to cover stability too.
    repeat (3) @(negedge clk);
    checks++;
    if (m_done !== 1'b1 || m_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_hold: got done=%0b busy=%0b, want done=1 busy=0", tag, m_done, m_busy);
    end
    checks++;
    if (m_err !== 32'(e_err) || m_lerr !== 32'(e_lerr)) begin
      errors++;
      $display("FAIL %s_counts: got err=%0d large=%0d, want err=%0d large=%0d",
               tag, m_err, m_lerr, e_err, e_lerr);
    end
    checks++;
    if (m_sum !== 48'(e_sum) || m_max !== 17'(e_max)) begin
      errors++;
      $display("FAIL %s_ed_stats: got sum=%0d max=%0d, want sum=%0d max=%0d",
               tag, m_sum, m_max, e_sum, e_max);
    end
  endtask

  task automatic test_exact();      do_run("exact", 1'b0, 0, 1000, 48, 0); endtask
  task automatic test_lsb_error();  do_run("lsb",   1'b0, 1, 100,  48, 0); endtask
  task automatic test_large_error(); do_run("large", 1'b0, 2, 50,   48, 0); endtask
  task automatic test_zero_samples(); do_run("zero", 1'b0, 1, 0,    48, 0); endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      mask = 16'($urandom);
      do_run("random", 1'b0, (i % 2 == 0) ? 3 : 5, 1 + int'($urandom_range(199)), 48, 0);
    end
  endtask

  task automatic test_back_to_back();
    do_run("b2b_first",  1'b0, 2, 7, 48, 0);
    do_run("b2b_second", 1'b0, 1, 5, 48, 0);
  endtask

  task automatic test_saturation();
    do_run("saturate", 1'b1, 4, 3, 8, 2);
  endtask

  task automatic test_reset_midrun();
    int cnt;
    sel = 1'b0; mode = 1; num_samples = 100; cnt = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (op_valid0) cnt++;
      if (cnt == 37) break;
    end
    checks++;
    if (cnt != 37) begin
      errors++;
      $display("FAIL midrun_reach: got %0d samples before reset point, want 37", cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy0, done0, op_valid0, op_a0, op_b0, err0, lerr0, sum0, max0} !== '0) begin
      errors++;
      $display("FAIL midrun_reset_outputs: got busy=%0b valid=%0b op_a=%h err=%0d sum=%0d max=%0d, want 0",
               busy0, op_valid0, op_a0, err0, sum0, max0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || op_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL midrun_idle_wait: got busy=%0b done=%0b valid=%0b, want 0 0 0",
               busy0, done0, op_valid0);
    end
    do_run("rerun", 1'b0, 1, 40, 48, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sel = 1'b0; num_samples = '0; mode = 0; mask = '0;
    test_reset();
    test_exact();
    test_lsb_error();
    test_large_error();
    test_zero_samples();
    test_random();
    test_back_to_back();
    test_saturation();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_err_monitor.md
ADDER_ERR_MONITOR -- requirements
Module: adder_err_monitor

Interface
REQ-001 The block SHALL have parameter N, default 16: operand and sum width of the adder under test.
REQ-002 The block SHALL have parameter K, default 12: large-error threshold exponent; an error distance (ED) >= 2^K counts as large.
REQ-003 The block SHALL have parameter CNT_W, default 32: sample-counter and error-counter width.
REQ-004 The block SHALL have parameter ACC_W, default 48: ED-sum accumulator width.
REQ-005 The block SHALL have parameter USE_CO, default 0: 1 compares the (N+1)-bit result including carry-out; 0 compares N-bit sums only.
REQ-006 The block SHALL have parameters SEED_A and SEED_B, defaults 32'hACE1_1234 and 32'h5EED_0001: non-zero operand LFSR seeds.
REQ-007 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 The block SHALL have port start, input, 1 bit: one-cycle request to begin a run.
REQ-010 The block SHALL have port num_samples, input, CNT_W bits: sample count, captured on accepted start.
REQ-011 The block SHALL have ports op_a and op_b, output, N bits each: registered operands driven to the external approximate adder.
REQ-012 The block SHALL have port op_valid, output, 1 bit: op_a/op_b hold a live sample this cycle.
REQ-013 The block SHALL have ports approx_sum, input, N bits, and approx_co, input, 1 bit: combinational adder response, sampled when op_valid=1.
REQ-014 The block SHALL have ports busy and done, output, 1 bit each: run in progress; results valid.
REQ-015 The block SHALL have ports err_count and large_err_count, output, CNT_W bits each: samples with ED != 0; samples with ED >= 2^K.
REQ-016 The block SHALL have port sum_ed, output, ACC_W bits: sum of ED.
REQ-017 The block SHALL have port max_ed, output, N+1 bits: largest ED seen.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DRAIN and DONE; busy=1 in RUN and DRAIN.
REQ-019 start in IDLE or DONE SHALL clear all result outputs and done, reload both LFSRs from their seeds, latch num_samples, and enter RUN, or DONE next cycle if num_samples=0.
REQ-020 start in RUN or DRAIN SHALL be ignored.
REQ-021 In RUN, op_valid SHALL be 1 for exactly num_samples consecutive cycles; each cycle both LFSRs advance and op_a/op_b take the low N bits of each.
REQ-022 Each LFSR SHALL be a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1.
REQ-023 The exact reference SHALL be a+b at N+1 bits; with USE_CO=0, bit N of both the exact and approximate values is forced to 0.
REQ-024 ED SHALL equal |approx - exact| at N+1 bits, unsigned.
REQ-025 Stage 1 SHALL register ED and a valid flag; stage 2 SHALL update all accumulators, giving 2-cycle latency from sample to results.
REQ-026 err_count, large_err_count and sum_ed SHALL saturate at all-ones and never wrap.
REQ-027 After the last op_valid cycle the FSM SHALL enter DRAIN for 2 cycles, then DONE with done=1.
REQ-028 In DONE, done and all results SHALL stay stable until the next accepted start.

Reset
REQ-029 On rst=1, at any time including mid-run, the FSM SHALL go to IDLE, all outputs SHALL be 0, LFSRs SHALL be loaded with SEED_A/SEED_B, and pipeline valids SHALL be cleared.
REQ-030 After rst deasserts, the block SHALL wait in IDLE for start.

Structure
REQ-031 A shared package adder_eval_pkg SHALL hold the FSM state typedef, the LFSR polynomial constant, and the default seeds.
REQ-032 The LFSR SHALL be a sub-module named eval_lfsr32 with clk, rst, load, seed, advance and q, instantiated twice.
REQ-033 No divider SHALL be present; software derives MED/MRED/NMED from the outputs.

Verification
REQ-034 Exact stub (approx=a+b), num_samples=1000 -> done; err_count=0, sum_ed=0, max_ed=0, large_err_count=0.
REQ-035 Stub approx=(a+b)^1, num_samples=100 -> err_count=100, sum_ed=100, max_ed=1, large_err_count=0.
REQ-036 Stub approx=(a+b)^16'h1000, K=12, num_samples=50 -> err_count=50, large_err_count=50, sum_ed=204800, max_ed=4096.
REQ-037 num_samples=0 -> op_valid never 1; done=1 one cycle after start; all results 0.
REQ-038 rst pulsed at sample 37 of a 100-sample run -> next cycle IDLE and all outputs 0; rerun reproduces the operand sequence of a fresh run.
REQ-039 ACC_W=8, stub ED=255, num_samples=3 -> sum_ed=255 (saturated); start during RUN -> no effect on the count.
